// File: rtl/tile_bevel_shader.sv
// Tile bevel shader: 2-stage pixel pipeline producing per-axis edge thermometers and a bevel level,
// with a frame-synchronous static/pulsing depth. Optional recessed-tile mode under `BEVEL_INVERT_EN.
module tile_bevel_shader #(
    parameter int TILE_LOG2 = 3,
    parameter int FRAME_DIV = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pix_valid,
    input  logic [15:0]                     row,
    input  logic [15:0]                     col,
    input  logic                            frame_start,
    input  logic [1:0]                      mode,
    input  logic                            depth_wr,
    input  logic [TILE_LOG2-1:0]            depth_in,
`ifdef BEVEL_INVERT_EN
    input  logic                            invert,
`endif
    output logic                            out_valid,
    output logic [2**(TILE_LOG2-1)-1:0]     r_therm,
    output logic [2**(TILE_LOG2-1)-1:0]     c_therm,
    output logic [TILE_LOG2-1:0]            level
);

    localparam int LEVELS = 2 ** (TILE_LOG2 - 1);
    localparam int LW     = TILE_LOG2;
    localparam int DW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [TILE_LOG2:0] TILE_W   = {1'b1, {TILE_LOG2{1'b0}}};
    localparam logic [LW-1:0]      LEVELS_W = {1'b1, {(LW-1){1'b0}}};
    localparam logic [DW-1:0]      DIV_LAST = DW'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_PULSE  = 2'd2
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Distance from an in-tile offset to the nearest tile edge.
    function automatic logic [LW-1:0] edge_dist(input logic [TILE_LOG2-1:0] o);
        logic [TILE_LOG2:0] far;
        far = TILE_W - {1'b0, o};
        if ({1'b0, o} <= far) return o;
        else                  return far[LW-1:0];
    endfunction

    function automatic logic [LW-1:0] min2(input logic [LW-1:0] a, input logic [LW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [LEVELS-1:0] therm(input logic [LW-1:0] d);
        logic [LEVELS-1:0] t;
        t = '0;
        for (int k = 0; k < LEVELS; k++) t[k] = (int'(d) > k);
        return t;
    endfunction

    // Only the in-tile offset bits of the coordinates matter.
    logic unused_coord_bits;
    assign unused_coord_bits = ^{row[15:TILE_LOG2], col[15:TILE_LOG2]};

    // ------------------------------------------------------------------
    // Frame-synchronous depth control
    // ------------------------------------------------------------------
    mode_e          mode_q, mode_d, new_mode;
    dir_e           dir_q, dir_d, step_dir;
    logic [DW-1:0]  div_q, div_d, step_div;
    logic [LW-1:0]  cur_depth, depth_d;
    logic [LW-1:0]  depth_shadow, shadow_d;
    logic           invert_q;

    always_comb begin
        case (mode)
            2'd1:    new_mode = MODE_STATIC;
            2'd2:    new_mode = MODE_PULSE;
            default: new_mode = MODE_OFF;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        div_d    = div_q;
        depth_d  = cur_depth;
        shadow_d = depth_shadow;
        // A fresh entry into PULSE restarts the divider and climbs from the current depth.
        step_dir = (mode_q == MODE_PULSE) ? dir_q : DIR_UP;
        step_div = (mode_q == MODE_PULSE) ? div_q : '0;

        if (depth_wr)
            shadow_d = (depth_in > LEVELS_W) ? LEVELS_W : depth_in;

        if (frame_start) begin
            mode_d = new_mode;
            case (new_mode)
                MODE_STATIC: depth_d = depth_shadow;
                MODE_PULSE: begin
                    dir_d = step_dir;
                    if (step_div == DIV_LAST) begin
                        div_d = '0;
                        if (step_dir == DIR_UP) begin
                            if (cur_depth == LEVELS_W) begin
                                dir_d   = DIR_DOWN;
                                depth_d = LEVELS_W - 1'b1;
                            end else begin
                                depth_d = cur_depth + 1'b1;
                            end
                        end else begin
                            if (cur_depth == '0) begin
                                dir_d   = DIR_UP;
                                depth_d = {{(LW-1){1'b0}}, 1'b1};
                            end else begin
                                depth_d = cur_depth - 1'b1;
                            end
                        end
                    end else begin
                        div_d = step_div + 1'b1;
                    end
                end
                default: begin
                    depth_d = '0;
                    dir_d   = DIR_UP;
                    div_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_OFF;
            dir_q        <= DIR_UP;
            div_q        <= '0;
            cur_depth    <= '0;
            depth_shadow <= LEVELS_W;
        end else begin
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            div_q        <= div_d;
            cur_depth    <= depth_d;
            depth_shadow <= shadow_d;
        end
    end

`ifdef BEVEL_INVERT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           invert_q <= 1'b0;
        else if (frame_start) invert_q <= invert;
    end
`else
    assign invert_q = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1: edge distances
    // ------------------------------------------------------------------
    logic          v1;
    logic [LW-1:0] dr1, dc1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            dr1 <= '0;
            dc1 <= '0;
        end else begin
            v1  <= pix_valid;
            dr1 <= edge_dist(row[TILE_LOG2-1:0]);
            dc1 <= edge_dist(col[TILE_LOG2-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: depth clamp, thermometers, level
    // ------------------------------------------------------------------
    logic [LW-1:0]     dr_c, dc_c, lvl_c;
    logic [LEVELS-1:0] rt_c, ct_c;

    always_comb begin
        dr_c  = min2(dr1, cur_depth);
        dc_c  = min2(dc1, cur_depth);
        lvl_c = min2(dr_c, dc_c);
        rt_c  = therm(dr_c);
        ct_c  = therm(dc_c);
        if (invert_q) begin
            rt_c  = ~rt_c;
            ct_c  = ~ct_c;
            lvl_c = LEVELS_W - lvl_c;
        end
        if (mode_q == MODE_OFF) begin
            rt_c  = '0;
            ct_c  = '0;
            lvl_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r_therm   <= '0;
            c_therm   <= '0;
            level     <= '0;
        end else begin
            out_valid <= v1;
            // Data outputs hold between valid pixels.
            if (v1) begin
                r_therm <= rt_c;
                c_therm <= ct_c;
                level   <= lvl_c;
            end
        end
    end

endmodule
